// File: rtl/window_stream.sv
// Streaming frame-based windowing unit: multiplies each accepted signed sample by a
// rect/Hann/Hamming coefficient chosen by its position in the frame. Three-stage pipeline.
module window_stream #(
    parameter int WIDTH      = 8,
    parameter int FRAME_LEN  = 4096,
    parameter int COEF_WIDTH = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  valid_in,
    input  logic [WIDTH-1:0]      in_sample,
    input  logic                  frame_start_in,
    input  logic [1:0]            mode_in,
    output logic                  valid_out,
    output logic [WIDTH-1:0]      out_sample,
    output logic                  frame_first_out,
    output logic                  frame_last_out
);

    localparam int  IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int  PROD_W = WIDTH + COEF_WIDTH + 1;
    localparam real PI     = 3.14159265358979323846;

    localparam logic [IDX_W-1:0]      IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [COEF_WIDTH-1:0] COEF_ONE = {1'b1, {(COEF_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_RECT    = 2'd0,
        MODE_HANN    = 2'd1,
        MODE_HAMMING = 2'd2,
        MODE_RSVD    = 2'd3
    } win_mode_e;

    // Raised-cosine coefficient in Q1.(COEF_WIDTH-1), rounded to nearest.
    function automatic logic [COEF_WIDTH-1:0] win_coef(input int n, input logic hamming);
        real c;
        real w;
        c = $cos(2.0 * PI * real'(n) / real'(FRAME_LEN - 1));
        if (hamming) begin
            w = 0.54 - 0.46 * c;
        end else begin
            w = 0.5 * (1.0 - c);
        end
        return COEF_WIDTH'($rtoi(w * real'(COEF_ONE) + 0.5));
    endfunction

    logic [COEF_WIDTH-1:0] hann_rom_s [FRAME_LEN];
    logic [COEF_WIDTH-1:0] hamm_rom_s [FRAME_LEN];

    for (genvar n = 0; n < FRAME_LEN; n++) begin : g_rom
        assign hann_rom_s[n] = win_coef(n, 1'b0);
        assign hamm_rom_s[n] = win_coef(n, 1'b1);
    end

    logic [IDX_W-1:0]      idx_r;
    win_mode_e             mode_r;

    logic [IDX_W-1:0]      cur_idx_s;
    logic [IDX_W-1:0]      next_idx_s;
    win_mode_e             cur_mode_s;
    logic                  is_first_s;
    logic                  is_last_s;
    logic [COEF_WIDTH-1:0] coef_s;

    logic                  s1_valid_r;
    logic [WIDTH-1:0]      s1_sample_r;
    logic [COEF_WIDTH-1:0] s1_coef_r;
    logic                  s1_first_r;
    logic                  s1_last_r;

    logic                  s2_valid_r;
    logic signed [PROD_W-1:0] prod_r;
    logic                  s2_first_r;
    logic                  s2_last_r;

    logic signed [PROD_W-1:0] mult_a_s;
    logic signed [PROD_W-1:0] mult_b_s;
    logic                  unused_prod_bits_s;

    // Index, window mode and coefficient for the sample presented this cycle
    always_comb begin
        if (frame_start_in) begin
            cur_idx_s = IDX_ZERO;
        end else begin
            cur_idx_s = idx_r;
        end
        is_first_s = (cur_idx_s == IDX_ZERO);
        is_last_s  = (cur_idx_s == LAST_IDX);
        if (is_first_s) begin
            cur_mode_s = win_mode_e'(mode_in);
        end else begin
            cur_mode_s = mode_r;
        end
        if (is_last_s) begin
            next_idx_s = IDX_ZERO;
        end else begin
            next_idx_s = cur_idx_s + IDX_ONE;
        end
        case (cur_mode_s)
            MODE_HANN:    coef_s = hann_rom_s[cur_idx_s];
            MODE_HAMMING: coef_s = hamm_rom_s[cur_idx_s];
            MODE_RECT:    coef_s = COEF_ONE;
            default:      coef_s = COEF_ONE;
        endcase
    end

    // Frame position and per-frame mode advance only on accepted samples
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            idx_r  <= IDX_ZERO;
            mode_r <= MODE_RECT;
        end else if (valid_in) begin
            idx_r  <= next_idx_s;
            mode_r <= cur_mode_s;
        end
    end

    // Stage 1: capture sample with its ROM coefficient and frame flags
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_valid_r  <= 1'b0;
            s1_sample_r <= {WIDTH{1'b0}};
            s1_coef_r   <= {COEF_WIDTH{1'b0}};
            s1_first_r  <= 1'b0;
            s1_last_r   <= 1'b0;
        end else begin
            s1_valid_r <= valid_in;
            if (valid_in) begin
                s1_sample_r <= in_sample;
                s1_coef_r   <= coef_s;
                s1_first_r  <= is_first_s;
                s1_last_r   <= is_last_s;
            end
        end
    end

    // Sign-extended sample times zero-extended coefficient, both at full product width
    assign mult_a_s = {{(COEF_WIDTH + 1){s1_sample_r[WIDTH-1]}}, s1_sample_r};
    assign mult_b_s = {{(WIDTH + 1){1'b0}}, s1_coef_r};

    // Stage 2: full-width signed multiply
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s2_valid_r <= 1'b0;
            prod_r     <= {PROD_W{1'b0}};
            s2_first_r <= 1'b0;
            s2_last_r  <= 1'b0;
        end else begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                prod_r     <= mult_a_s * mult_b_s;
                s2_first_r <= s1_first_r;
                s2_last_r  <= s1_last_r;
            end
        end
    end

    // The slice below equals an arithmetic right shift by COEF_WIDTH-1 truncated to WIDTH;
    // the remaining bits are sign copies or fraction and carry no information.
    assign unused_prod_bits_s = ^{prod_r[PROD_W-1:COEF_WIDTH-1+WIDTH], prod_r[COEF_WIDTH-2:0]};

    // Stage 3: scaled result and flags, holding the last sample while idle
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_out       <= 1'b0;
            out_sample      <= {WIDTH{1'b0}};
            frame_first_out <= 1'b0;
            frame_last_out  <= 1'b0;
        end else begin
            valid_out       <= s2_valid_r;
            frame_first_out <= s2_valid_r & s2_first_r;
            frame_last_out  <= s2_valid_r & s2_last_r;
            if (s2_valid_r) begin
                out_sample <= prod_r[COEF_WIDTH-1 +: WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_window_stream.sv
// Directed bench for window_stream (FRAME_LEN=8): a frame-level reference model predicts
// every output cycle; a few hand-computed values pin the model and the DUT.
module tb_window_stream;

    localparam int WIDTH = 8;
    localparam int N     = 8;
    localparam int CW    = 16;
    localparam int DEPTH = 2048;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b0;
    logic             valid_in = 1'b0;
    logic [WIDTH-1:0] in_sample = 8'd0;
    logic             frame_start_in = 1'b0;
    logic [1:0]       mode_in = 2'd0;
    logic             valid_out;
    logic [WIDTH-1:0] out_sample;
    logic             frame_first_out;
    logic             frame_last_out;

    window_stream #(.WIDTH(WIDTH), .FRAME_LEN(N), .COEF_WIDTH(CW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .in_sample(in_sample),
        .frame_start_in(frame_start_in), .mode_in(mode_in), .valid_out(valid_out),
        .out_sample(out_sample), .frame_first_out(frame_first_out),
        .frame_last_out(frame_last_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Expected output per cycle number, filled when a sample is driven
    bit exp_v [DEPTH];
    int exp_out [DEPTH];
    bit exp_first [DEPTH];
    bit exp_last [DEPTH];
    int dut_at [DEPTH];
    bit dut_first_at [DEPTH];
    int exp_hold = 0;
    int m_idx = 0;
    int m_mode = 0;
    int last_out_cyc = 0;
    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic int model_coef(input int mode, input int n);
        real c;
        c = $cos(2.0 * 3.14159265358979323846 * real'(n) / real'(N - 1));
        if (mode == 1) return $rtoi(0.5 * (1.0 - c) * 32768.0 + 0.5);
        else if (mode == 2) return $rtoi((0.54 - 0.46 * c) * 32768.0 + 0.5);
        else return 32768;
    endfunction

    function automatic int model_out(input int mode, input int n, input int s);
        int p;
        p = s * model_coef(mode, n);
        return p >>> 15;
    endfunction

    task automatic drive(input bit v, input int s, input bit fs, input int m);
        int idx;
        if (v && rst_in) begin
            idx = fs ? 0 : m_idx;
            if (idx == 0) m_mode = m;
            exp_v[cyc + 3]     = 1'b1;
            exp_out[cyc + 3]   = model_out(m_mode, idx, s);
            exp_first[cyc + 3] = (idx == 0);
            exp_last[cyc + 3]  = (idx == N - 1);
            last_out_cyc       = cyc + 3;
            m_idx = (idx == N - 1) ? 0 : idx + 1;
        end
        valid_in = v;
        in_sample = 8'(s);
        frame_start_in = fs;
        mode_in = 2'(m);
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_reset();
        rst_in = 1'b0;
        #1;
        check("valid_out_async_reset", int'(valid_out), 0);
        check("out_sample_async_reset", int'($signed(out_sample)), 0);
        for (int i = cyc; i < DEPTH; i++) exp_v[i] = 1'b0;
        exp_hold = 0;
        m_idx = 0;
        m_mode = 0;
        valid_in = 1'b0;
        frame_start_in = 1'b0;
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    // Every cycle after the first edge: outputs against the model's per-cycle prediction
    always @(negedge clk_in) begin : compare
        int req;
        if (cyc > 0) begin
            req = exp_v[cyc] ? exp_out[cyc] : exp_hold;
            check("valid_out", int'(valid_out), int'(exp_v[cyc]));
            check("frame_first_out", int'(frame_first_out), int'(exp_v[cyc] && exp_first[cyc]));
            check("frame_last_out", int'(frame_last_out), int'(exp_v[cyc] && exp_last[cyc]));
            check("out_sample", int'($signed(out_sample)), req);
            dut_at[cyc] = int'($signed(out_sample));
            dut_first_at[cyc] = frame_first_out;
            exp_hold = req;
        end
    end

    int vals1 [8] = '{100, -128, 127, 5, -1, 0, 64, -64};
    int c_rect0, c_h0, c_h3, c_h7, c_r0, c_m0, c_p0, c_t0, c_z0;

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        check("reset_valid_out", int'(valid_out), 0);
        rst_in = 1'b1;

        // Model pinned against hand-computed values
        check("model_hann_idx3", model_out(1, 3, 100), 95);
        check("model_hamming_coef0", model_coef(2, 0), 2621);
        check("model_hamming_neg", model_out(2, 0, -128), -11);

        // Rect passthrough frame, explicit frame start
        for (int i = 0; i < N; i++) begin
            drive(1'b1, vals1[i], i == 0, 0);
            if (i == 0) c_rect0 = last_out_cyc;
        end
        // Hann frame, mode_in changes mid-frame (no effect until next frame)
        for (int i = 0; i < N; i++) begin
            drive(1'b1, 100, 1'b0, (i < 4) ? 1 : 0);
            if (i == 0) c_h0 = last_out_cyc;
            if (i == 3) c_h3 = last_out_cyc;
            if (i == 7) c_h7 = last_out_cyc;
        end
        // Rect frame, frame_start coinciding with natural wrap
        for (int i = 0; i < N; i++) begin
            drive(1'b1, 100, i == 0, 0);
            if (i == 0) c_r0 = last_out_cyc;
        end
        // Hamming frames; reserved mode requested mid-frame is ignored
        for (int i = 0; i < N; i++) begin
            drive(1'b1, -128, i == 0, 2);
            if (i == 0) c_m0 = last_out_cyc;
        end
        for (int i = 0; i < N; i++) begin
            drive(1'b1, (i == 0) ? 127 : i * 17 - 60, 1'b0, (i == 0) ? 2 : 3);
            if (i == 0) c_p0 = last_out_cyc;
        end
        // Gapped Hann frame truncated at idx 5 by frame_start, then a gapped Hamming frame
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 20 + i * 9, 1'b0, 1);
            drive(1'b0, 0, 1'b1, 0);
        end
        drive(1'b1, 90, 1'b1, 2);
        c_t0 = last_out_cyc;
        for (int i = 1; i < N; i++) begin
            drive(1'b0, 0, 1'b0, 1);
            drive(1'b1, 11 * i - 40, 1'b0, 1);
        end
        // Reserved mode at frame start acts as rect
        for (int i = 0; i < 3; i++) drive(1'b1, -37 + i, i == 0, 3);
        // Reset mid-frame with samples in flight
        for (int i = 0; i < 4; i++) drive(1'b1, 50 + i, i == 0, 1);
        check("valid_out_before_reset", int'(valid_out), 1);
        pulse_reset();
        drive(1'b1, -77, 1'b0, 0);
        c_z0 = last_out_cyc;
        drive(1'b1, 33, 1'b0, 1);
        drive(1'b1, -5, 1'b0, 1);
        for (int i = 0; i < 6; i++) drive(1'b0, 0, 1'b0, 0);

        // Hand-computed DUT values at known output cycles
        check("rect_100", dut_at[c_rect0], 100);
        check("rect_neg128", dut_at[c_rect0 + 1], -128);
        check("rect_127", dut_at[c_rect0 + 2], 127);
        check("hann_idx0", dut_at[c_h0], 0);
        check("hann_idx3", dut_at[c_h3], 95);
        check("hann_idx7", dut_at[c_h7], 0);
        check("rect_after_hann", dut_at[c_r0], 100);
        check("hamming_neg128", dut_at[c_m0], -11);
        check("hamming_127", dut_at[c_p0], 10);
        check("realign_value", dut_at[c_t0], 7);
        check("realign_first", int'(dut_first_at[c_t0]), 1);
        check("after_reset_rect", dut_at[c_z0], -77);
        check("after_reset_first", int'(dut_first_at[c_z0]), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
